// File: rtl/axi_wr_scheduler.sv
// Write-path scheduler for a shared AXI master port: locked round-robin AW arbitration,
// in-order W steering from the recorded grant order, B routing and an outstanding-write limit.
module axi_wr_scheduler #(
    parameter int unsigned NumInp         = 3,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1),
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic [NumInp-1:0] aw_valid_i,
    output logic [NumInp-1:0] aw_ready_o,
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [IdxW-1:0]   aw_sel_o,
    input  logic [NumInp-1:0] w_valid_i,
    input  logic [NumInp-1:0] w_last_i,
    output logic [NumInp-1:0] w_ready_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [IdxW-1:0]   w_sel_o,
    input  logic              b_valid_i,
    input  logic [IdxW-1:0]   b_src_i,
    output logic              b_ready_o,
    output logic [NumInp-1:0] b_valid_o,
    input  logic [NumInp-1:0] b_ready_i,
    output logic [CntW-1:0]   outstanding_o,
    output logic              busy_o,
    output logic              err_o
);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_sel_q, lock_sel_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic            err_q, err_d;
    logic [IdxW-1:0] fifo_mem_q [MaxOutstanding];

    logic            rr_found;
    logic [IdxW-1:0] rr_winner;
    logic            aw_req;
    logic            aw_gate;
    logic            aw_hs;
    logic            fifo_empty;
    logic            fifo_full;
    logic [IdxW-1:0] fifo_head;
    logic            w_pop;
    logic            b_hs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        logic [IdxW-1:0] cand;
        cand      = '0;
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 0; k < NumInp; k++) begin
            cand = IdxW'((int'(rr_ptr_q) + k) % NumInp);
            if (!rr_found && aw_valid_i[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
        end
    end

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CntW'(MaxOutstanding));
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign aw_gate    = (outstanding_q == CntW'(MaxOutstanding)) | fifo_full;

    assign aw_sel_o   = lock_q ? lock_sel_q : rr_winner;
    assign aw_req     = lock_q ? aw_valid_i[lock_sel_q] : rr_found;
    assign aw_valid_o = aw_req & ~aw_gate;
    assign aw_hs      = aw_valid_o & aw_ready_i;

    assign w_sel_o    = fifo_empty ? '0 : fifo_head;
    assign w_valid_o  = ~fifo_empty & w_valid_i[fifo_head];
    assign w_pop      = w_valid_o & w_ready_i & w_last_i[fifo_head];

    assign b_ready_o  = b_ready_i[b_src_i];
    assign b_hs       = b_valid_i & b_ready_o;

    assign outstanding_o = outstanding_q;
    assign busy_o        = (outstanding_q != '0) | ~fifo_empty;
    assign err_o         = err_q;

    for (genvar gi = 0; gi < NumInp; gi++) begin : g_port
        assign aw_ready_o[gi] = aw_hs & (aw_sel_o == IdxW'(gi));
        assign w_ready_o[gi]  = ~fifo_empty & w_ready_i & (fifo_head == IdxW'(gi));
        assign b_valid_o[gi]  = b_valid_i & (b_src_i == IdxW'(gi));
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        lock_d        = lock_q;
        lock_sel_d    = lock_sel_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        if (aw_hs) begin
            rr_ptr_d = (aw_sel_o == IdxW'(NumInp - 1)) ? '0 : aw_sel_o + IdxW'(1);
            lock_d   = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else if (aw_valid_o) begin
            // Hold the presented request stable until the port accepts it.
            lock_d     = 1'b1;
            lock_sel_d = aw_sel_o;
        end

        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (aw_hs && !w_pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (w_pop && !aw_hs) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end

        if (aw_hs && !b_hs) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (b_hs && !aw_hs && outstanding_q != '0) begin
            outstanding_d = outstanding_q - CntW'(1);
        end
        if (b_hs && outstanding_q == '0) begin
            err_d = 1'b1;
        end

        if (clr_i) begin
            rr_ptr_d      = '0;
            lock_d        = 1'b0;
            lock_sel_d    = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            fifo_cnt_d    = '0;
            outstanding_d = '0;
            err_d         = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q      <= '0;
            lock_q        <= 1'b0;
            lock_sel_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            lock_q        <= lock_d;
            lock_sel_q    <= lock_sel_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Entry storage needs no reset: the occupancy count decides what is valid.
    always_ff @(posedge clk_i) begin
        if (aw_hs) begin
            fifo_mem_q[wr_ptr_q] <= aw_sel_o;
        end
    end

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Bench for axi_wr_scheduler: directed scenarios plus randomized traffic, checked against a
// queue-based reference model through an expectation scoreboard and a W-order scoreboard.
module tb_axi_wr_scheduler;

    localparam int N    = 3;
    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       clr_i;
    logic [2:0] aw_valid_i;
    logic [2:0] aw_ready_o;
    logic       aw_valid_o;
    logic       aw_ready_i;
    logic [1:0] aw_sel_o;
    logic [2:0] w_valid_i;
    logic [2:0] w_last_i;
    logic [2:0] w_ready_o;
    logic       w_valid_o;
    logic       w_ready_i;
    logic [1:0] w_sel_o;
    logic       b_valid_i;
    logic [1:0] b_src_i;
    logic       b_ready_o;
    logic [2:0] b_valid_o;
    logic [2:0] b_ready_i;
    logic [2:0] outstanding_o;
    logic       busy_o;
    logic       err_o;

    always #5 clk = ~clk;

    axi_wr_scheduler #(.NumInp(N), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_valid_o(aw_valid_o),
        .aw_ready_i(aw_ready_i), .aw_sel_o(aw_sel_o),
        .w_valid_i(w_valid_i), .w_last_i(w_last_i), .w_ready_o(w_ready_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_sel_o(w_sel_o),
        .b_valid_i(b_valid_i), .b_src_i(b_src_i), .b_ready_o(b_ready_o),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        int cyc;
        bit aw_valid; int aw_sel; int aw_ready;
        bit w_valid;  int w_sel;  int w_ready;
        bit b_ready;  int b_valid;
        int outstanding; bit busy; bit err;
    } exp_t;

    exp_t exp_q[$];
    int   wexp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Reference model state
    int m_rr, m_lock_idx, m_out;
    bit m_lock, m_err;
    int m_fifo[$];

    // Random traffic agents (requesters and AXI slave)
    bit rand_mode = 0;
    bit ag_aw_pend[N];
    int ag_wq[N][$];
    int ag_beat[N];
    int sl_pend[$];

    task automatic model_reset();
        m_rr = 0; m_lock = 0; m_lock_idx = 0; m_out = 0; m_err = 0;
        m_fifo.delete();
        for (int i = 0; i < N; i++) begin
            ag_aw_pend[i] = 0; ag_wq[i].delete(); ag_beat[i] = 0;
        end
        sl_pend.delete();
    endtask

    // Predict this cycle's outputs from the driven inputs, queue them, advance the model.
    task automatic model_eval();
        exp_t e;
        bit found, gate, aw_hs, w_hs, pop, b_hs;
        int win, h;
        if (!rst_ni) model_reset();
        gate  = (m_out == MAXO) || (m_fifo.size() == MAXO);
        found = 0; win = 0;
        if (m_lock) begin
            win = m_lock_idx; found = aw_valid_i[m_lock_idx];
        end else begin
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (!found && aw_valid_i[c]) begin found = 1; win = c; end
            end
        end
        e.cyc      = cyc_no;
        e.aw_sel   = win;
        e.aw_valid = found && !gate;
        aw_hs      = e.aw_valid && aw_ready_i;
        e.aw_ready = aw_hs ? (1 << win) : 0;
        h = 0;
        if (m_fifo.size() == 0) begin
            e.w_sel = 0; e.w_valid = 0; e.w_ready = 0;
        end else begin
            h = m_fifo[0];
            e.w_sel = h; e.w_valid = w_valid_i[h]; e.w_ready = w_ready_i ? (1 << h) : 0;
        end
        w_hs = e.w_valid && w_ready_i;
        pop  = w_hs && w_last_i[h];
        e.b_ready     = b_ready_i[b_src_i];
        e.b_valid     = b_valid_i ? (1 << b_src_i) : 0;
        b_hs          = b_valid_i && e.b_ready;
        e.outstanding = m_out;
        e.busy        = (m_out != 0) || (m_fifo.size() != 0);
        e.err         = m_err;
        exp_q.push_back(e);

        if (!rst_ni || clr_i) begin
            model_reset();
        end else begin
            if (aw_hs) begin
                m_fifo.push_back(win);
                wexp_q.push_back(win);
                m_rr = (win + 1) % N;
                m_lock = 0;
            end else if (e.aw_valid) begin
                m_lock = 1; m_lock_idx = win;
            end
            if (pop) void'(m_fifo.pop_front());
            if (b_hs && m_out == 0) m_err = 1;
            if (aw_hs && !b_hs) m_out++;
            else if (b_hs && !aw_hs && m_out > 0) m_out--;
            if (rand_mode) begin
                if (aw_hs) begin ag_aw_pend[win] = 0; sl_pend.push_back(win); end
                if (w_hs) begin
                    ag_beat[h]++;
                    if (pop && ag_wq[h].size() > 0) begin
                        void'(ag_wq[h].pop_front()); ag_beat[h] = 0;
                    end
                end
                if (b_hs && sl_pend.size() > 0) void'(sl_pend.pop_front());
            end
        end
    endtask

    task automatic cyc(input logic [2:0] awv, input logic awr, input logic [2:0] wv,
                       input logic [2:0] wl, input logic wr, input logic bv,
                       input logic [1:0] bs, input logic [2:0] br, input logic clr,
                       input logic rstn);
        @(negedge clk);
        cyc_no++;
        rst_ni = rstn; clr_i = clr;
        aw_valid_i = awv; aw_ready_i = awr;
        w_valid_i = wv; w_last_i = wl; w_ready_i = wr;
        b_valid_i = bv; b_src_i = bs; b_ready_i = br;
        model_eval();
    endtask

    task automatic idle(input logic clr);
        cyc(3'b0, 1'b0, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, clr, 1'b1);
    endtask

    task automatic rand_cyc();
        @(negedge clk);
        cyc_no++;
        rst_ni = 1'b1; clr_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!ag_aw_pend[i] && $urandom_range(0, 3) == 0) begin
                ag_aw_pend[i] = 1;
                ag_wq[i].push_back(int'($urandom_range(1, 4)));
            end
            aw_valid_i[i] = ag_aw_pend[i];
            w_valid_i[i]  = (ag_wq[i].size() > 0) && ($urandom_range(0, 9) < 7);
            w_last_i[i]   = (ag_wq[i].size() > 0) && (ag_beat[i] + 1 == ag_wq[i][0]);
        end
        aw_ready_i = ($urandom_range(0, 9) < 6);
        w_ready_i  = ($urandom_range(0, 9) < 7);
        b_ready_i  = 3'($urandom_range(0, 7));
        if (sl_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
            b_valid_i = 1'b1; b_src_i = 2'(sl_pend[0]);
        end else begin
            b_valid_i = 1'b0; b_src_i = 2'($urandom_range(0, 2));
        end
        model_eval();
    endtask

    task automatic chk(input string name, input int c, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
        end
    endtask

    // Monitor: compares every queued expectation, and checks W beats against grant order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("aw_valid",    e.cyc, int'(aw_valid_o),    int'(e.aw_valid));
                chk("aw_sel",      e.cyc, int'(aw_sel_o),      e.aw_sel);
                chk("aw_ready",    e.cyc, int'(aw_ready_o),    e.aw_ready);
                chk("w_valid",     e.cyc, int'(w_valid_o),     int'(e.w_valid));
                chk("w_sel",       e.cyc, int'(w_sel_o),       e.w_sel);
                chk("w_ready",     e.cyc, int'(w_ready_o),     e.w_ready);
                chk("b_ready",     e.cyc, int'(b_ready_o),     int'(e.b_ready));
                chk("b_valid",     e.cyc, int'(b_valid_o),     e.b_valid);
                chk("outstanding", e.cyc, int'(outstanding_o), e.outstanding);
                chk("busy",        e.cyc, int'(busy_o),        int'(e.busy));
                chk("err",         e.cyc, int'(err_o),         int'(e.err));
                if (w_valid_o && w_ready_i) begin
                    if (wexp_q.size() == 0) begin
                        chk("w_order_empty", e.cyc, int'(w_sel_o), -1);
                    end else begin
                        chk("w_order", e.cyc, int'(w_sel_o), wexp_q[0]);
                        if (w_last_i[w_sel_o]) void'(wexp_q.pop_front());
                    end
                end
                if (!rst_ni || clr_i) wexp_q.delete();
            end
        end
    end

    initial begin
        rst_ni = 1'b0; clr_i = 1'b0;
        aw_valid_i = '0; aw_ready_i = 1'b0; w_valid_i = '0; w_last_i = '0;
        w_ready_i = 1'b0; b_valid_i = 1'b0; b_src_i = '0; b_ready_i = '0;
        model_reset();

        // Reset state
        cyc(3'b0, 1'b0, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b0);
        cyc(3'b111, 1'b1, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b0);
        idle(1'b0);

        // Round-robin: grants 0,1,2,0 then limit reached
        repeat (5) cyc(3'b111, 1'b1, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Lock: req 2 held while req 0 rises; req 0 granted afterwards
        cyc(3'b100, 1'b0, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        repeat (2) cyc(3'b101, 1'b0, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b101, 1'b1, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b001, 1'b1, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        idle(1'b1);

        // W ordering: grants 1 then 2; req 2 waits behind req 1's 4-beat burst
        cyc(3'b010, 1'b1, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b100, 1'b1, 3'b100, 3'b000, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        repeat (2) cyc(3'b0, 1'b0, 3'b100, 3'b000, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        repeat (3) cyc(3'b0, 1'b0, 3'b110, 3'b000, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b0, 1'b0, 3'b110, 3'b010, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b0, 1'b0, 3'b100, 3'b100, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Limit, release by B, then simultaneous AW+B and push+pop
        repeat (6) cyc(3'b111, 1'b1, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b111, 1'b1, 3'b0, 3'b0, 1'b0, 1'b1, 2'd0, 3'b111, 1'b0, 1'b1);
        cyc(3'b111, 1'b0, 3'b0, 3'b0, 1'b0, 1'b0, 2'd0, 3'b0, 1'b0, 1'b1);
        cyc(3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 2'd1, 3'b111, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Error: B at zero outstanding, sticky until clear
        cyc(3'b0, 1'b0, 3'b0, 3'b0, 1'b0, 1'b1, 2'd2, 3'b111, 1'b0, 1'b1);
        repeat (2) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic
        rand_mode = 1;
        repeat (3000) rand_cyc();

        // Asynchronous reset in the middle of traffic
        cyc(3'b111, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0, 2'd0, 3'b0, 1'b0, 1'b0);
        idle(1'b0);
        repeat (200) rand_cyc();
        rand_mode = 0;
        idle(1'b1);

        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_wr_scheduler.md
# axi_wr_scheduler

Write-path scheduler for the cache subsystem's shared AXI master port. It arbitrates AW requests from up to `NumInp` cache-side requesters (I$, D$ bypass, D$ refill/write-back) with locked round-robin. It records the grant order so W beats are forwarded from exactly one requester per burst, in AW order. It routes B responses back by decoded source and bounds outstanding writes. Payload muxing stays outside; this block only produces selects and valid/ready.

## Interface
- `NumInp`, default 3: number of requesters; index 0 has highest initial priority.
- `MaxOutstanding`, default 4: maximum AWs accepted but not yet answered on B. Also the depth of the W-order FIFO.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clr_i` in 1: synchronous clear; same effect as reset.
- `aw_valid_i` in NumInp: per-requester AW valid.
- `aw_ready_o` out NumInp: per-requester AW ready.
- `aw_valid_o` out 1: AW valid to the AXI port.
- `aw_ready_i` in 1: AW ready from the AXI port.
- `aw_sel_o` out $clog2(NumInp): index of the requester whose AW payload drives the port.
- `w_valid_i` in NumInp: per-requester W valid.
- `w_last_i` in NumInp: per-requester W last.
- `w_ready_o` out NumInp: per-requester W ready.
- `w_valid_o` out 1: W valid to the AXI port.
- `w_ready_i` in 1: W ready from the AXI port.
- `w_sel_o` out $clog2(NumInp): W payload select.
- `b_valid_i` in 1: B valid from the AXI port.
- `b_src_i` in $clog2(NumInp): requester index decoded externally from the B ID.
- `b_ready_o` out 1: B ready to the AXI port.
- `b_valid_o` out NumInp: per-requester B valid.
- `b_ready_i` in NumInp: per-requester B ready.
- `outstanding_o` out $clog2(MaxOutstanding+1): writes in flight.
- `busy_o` out 1: set when `outstanding_o != 0` or the FIFO is non-empty.
- `err_o` out 1: sticky; set by a B handshake while `outstanding_o == 0`.

## Operation
- **AW arbitration**
  - Round-robin: search starts at `rr_ptr`. On each AW handshake, `rr_ptr` ← winner+1, with wrap from NumInp-1 to 0.
  - Lock: once `aw_valid_o` is high, `aw_sel_o` and the lock register hold until `aw_ready_i`, even if higher-priority inputs rise. This keeps the port AXI-stable.
  - Gate: `aw_valid_o` is suppressed while `outstanding_o == MaxOutstanding` or the FIFO is full. A locked request is never dropped; it waits.
  - `aw_ready_o[i] = aw_ready_i & aw_valid_o & (aw_sel_o == i)`.
- **W-order FIFO**
  - Push the winner index on AW handshake.
  - Pop on `w_valid_o & w_ready_i & w_last_i[w_sel_o]`.
  - The head drives `w_sel_o`. When empty: `w_sel_o = 0`, `w_valid_o = 0`, and all `w_ready_o = 0`.
  - No fall-through.
  - `w_valid_o = ~empty & w_valid_i[head]`; `w_ready_o[head] = w_ready_i`.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- **B routing**
  - `b_valid_o[b_src_i] = b_valid_i`; `b_ready_o = b_ready_i[b_src_i]`. No B state.
- **Outstanding counter**
  - +1 on AW handshake, -1 on B handshake; unchanged when both occur in the same cycle.
  - Saturates at 0 on an underflow B, and `err_o` is set.

## Timing
- Reset/clr values: `rr_ptr = 0`, lock = 0, FIFO empty, `outstanding_o = 0`, `err_o = 0`.
  - Resulting outputs: `busy_o = 0`, all valid/ready outputs 0, `aw_sel_o = 0`, `w_sel_o = 0`.
- AW path: combinational, 0-cycle from `aw_valid_i` to `aw_valid_o`.
- W path: the earliest W beat of a burst is accepted the cycle after its AW handshake. W-only bursts before AW are not accepted.
- B path: fully combinational pass-through.
- Reset or `clr_i` mid-burst drops all state immediately. Requesters must be reset together with this block.
- A single-beat burst (last on the first beat) pops in the same cycle it is accepted. The next FIFO entry is presented in the following cycle.

## Test plan
- **Round-robin:** all 3 `aw_valid_i` high and continuous, `aw_ready_i = 1` → grants 0,1,2,0; `rr_ptr` wraps.
- **Lock:** req 2 valid and `aw_ready_i = 0` for 3 cycles, req 0 rises in cycle 1 → `aw_sel_o` stays 2 until the handshake; req 0 is granted next.
- **W ordering:** AWs granted in order 1 then 2, req 2 presents W first → no req-2 beat is accepted until req 1's 4-beat burst completes with last; then req 2's beats pass.
- **Limit:** 4 AWs accepted with no B → `outstanding_o = 4`, `aw_valid_o = 0` with requests pending. One B handshake → `aw_valid_o` rises the next cycle.
- **Simultaneous events:** AW handshake and B handshake in the same cycle → count unchanged. FIFO push and pop in the same cycle → occupancy unchanged.
- **Error:** B handshake at `outstanding_o = 0` → `err_o = 1` and stays set; count stays 0. `clr_i` clears `err_o`.
